// File: rtl/udp_cmd_pkg.sv
// Shared definitions for the UDP host-command controller: defaults, opcodes,
// status codes, FSM encoding and the packet validation rule.
package udp_cmd_pkg;

  localparam logic [31:0] CMD_MAGIC_DEF    = 32'h4F56_3536;
  localparam logic [23:0] SCCB_TIMEOUT_DEF = 24'd1_000_000;

  localparam logic [7:0] OP_CAM_ON    = 8'h01;
  localparam logic [7:0] OP_CAM_OFF   = 8'h02;
  localparam logic [7:0] OP_FRAME_DIV = 8'h03;
  localparam logic [7:0] OP_SCCB_WR   = 8'h04;

  localparam logic [7:0] ST_OK        = 8'h00;
  localparam logic [7:0] ST_BAD_LEN   = 8'h01;
  localparam logic [7:0] ST_BAD_MAGIC = 8'h02;
  localparam logic [7:0] ST_BAD_OP    = 8'h03;
  localparam logic [7:0] ST_BAD_MASK  = 8'h04;
  localparam logic [7:0] ST_SCCB_TMO  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_EXEC  = 3'd2,
    S_SCCB  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Status for a collected packet; earlier checks take priority over later ones.
  function automatic logic [7:0] check_code(input logic        len_ok,
                                            input logic [1:0]  words,
                                            input logic        oversize,
                                            input logic [31:0] w0,
                                            input logic [31:0] w1,
                                            input logic [31:0] magic);
    if (!len_ok || words != 2'd3 || oversize) return ST_BAD_LEN;
    if (w0 != magic) return ST_BAD_MAGIC;
    if (w1[31:24] < OP_CAM_ON || w1[31:24] > OP_SCCB_WR) return ST_BAD_OP;
    if (w1[23:18] != 6'd0 || w1[23:16] == 8'd0) return ST_BAD_MASK;
    return ST_OK;
  endfunction

endpackage

// File: rtl/udp_cmd_sccb_seq.sv
// Walks the camera mask issuing one SCCB write per selected camera, with a
// per-write acknowledge timeout.
module udp_cmd_sccb_seq
  import udp_cmd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = SCCB_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mask,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        ack,
  output logic        req,
  output logic        cam,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        done,
  output logic        timeout
);

  logic [23:0] cnt;
  logic        second;
  logic        gap;

  assign done    = req & ack & ~second;
  assign timeout = req & ~ack & (cnt == TIMEOUT - 24'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req    <= 1'b0;
      cam    <= 1'b0;
      addr   <= 16'd0;
      data   <= 8'd0;
      cnt    <= 24'd0;
      second <= 1'b0;
      gap    <= 1'b0;
    end else if (start) begin
      req    <= 1'b1;
      cam    <= ~mask[0];
      second <= mask[0] & mask[1];
      addr   <= wr_addr;
      data   <= wr_data;
      cnt    <= 24'd0;
      gap    <= 1'b0;
    end else if (gap) begin
      // one low cycle between the camera 0 and camera 1 requests
      gap <= 1'b0;
      req <= 1'b1;
      cnt <= 24'd0;
    end else if (req) begin
      if (ack) begin
        req <= 1'b0;
        if (second) begin
          second <= 1'b0;
          cam    <= 1'b1;
          gap    <= 1'b1;
        end
      end else if (cnt == TIMEOUT - 24'd1) begin
        req    <= 1'b0;
        second <= 1'b0;
      end else begin
        cnt <= cnt + 24'd1;
      end
    end
  end

endmodule

// File: rtl/udp_cmd_ctrl.sv
// Collects a UDP payload, validates it as a 12-byte command, executes it and
// returns exactly one status response per accepted packet.
module udp_cmd_ctrl
  import udp_cmd_pkg::*;
#(
  parameter logic [31:0] CMD_MAGIC    = CMD_MAGIC_DEF,
  parameter logic [23:0] SCCB_TIMEOUT = SCCB_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_en,
  input  logic [31:0] rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  output logic [1:0]  cam_en,
  output logic [3:0]  frame_div0,
  output logic [3:0]  frame_div1,
  output logic        sccb_req,
  output logic        sccb_cam,
  output logic [15:0] sccb_addr,
  output logic [7:0]  sccb_data,
  input  logic        sccb_ack,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_code,
  output logic [15:0] resp_seq,
  output logic [15:0] drop_cnt,
  output logic [2:0]  fsm_state
);

  // Response handshake: resp_valid rises with resp_code/resp_seq stable and
  // holds them until a cycle with resp_ready=1; that cycle is the transfer.
  state_t      state;
  logic [31:0] slot [3];
  logic [1:0]  word_cnt;
  logic        oversize;
  logic        len_ok;
  logic [7:0]  chk_code;
  logic [7:0]  opcode;
  logic [1:0]  mask;
  logic [31:0] arg;
  logic        seq_start;
  logic        seq_done;
  logic        seq_timeout;

  assign opcode    = slot[1][31:24];
  assign mask      = slot[1][17:16];
  assign arg       = slot[2];
  assign chk_code  = check_code(len_ok, word_cnt, oversize, slot[0], slot[1], CMD_MAGIC);
  // SCCB writes skip EXEC so the request rises two cycles after the packet end.
  assign seq_start = (state == S_CHECK) && (chk_code == ST_OK) && (opcode == OP_SCCB_WR);
  assign fsm_state = state;

  udp_cmd_sccb_seq #(.TIMEOUT(SCCB_TIMEOUT)) u_sccb_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (seq_start),
    .mask    (mask),
    .wr_addr (arg[31:16]),
    .wr_data (arg[7:0]),
    .ack     (sccb_ack),
    .req     (sccb_req),
    .cam     (sccb_cam),
    .addr    (sccb_addr),
    .data    (sccb_data),
    .done    (seq_done),
    .timeout (seq_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      slot[0]    <= 32'd0;
      slot[1]    <= 32'd0;
      slot[2]    <= 32'd0;
      word_cnt   <= 2'd0;
      oversize   <= 1'b0;
      len_ok     <= 1'b0;
      cam_en     <= 2'd0;
      frame_div0 <= 4'd0;
      frame_div1 <= 4'd0;
      resp_valid <= 1'b0;
      resp_code  <= 8'd0;
      resp_seq   <= 16'd0;
      drop_cnt   <= 16'd0;
    end else begin
      if (rec_pkt_done && state != S_IDLE && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (rec_en) begin
            if (word_cnt == 2'd3) begin
              oversize <= 1'b1;
            end else begin
              slot[word_cnt] <= rec_data;
              word_cnt       <= word_cnt + 2'd1;
            end
          end
          if (rec_pkt_done) begin
            len_ok <= (rec_byte_num == 16'd12);
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          resp_seq <= slot[1][15:0];
          if (chk_code != ST_OK) begin
            resp_code  <= chk_code;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (opcode == OP_SCCB_WR) begin
            state <= S_SCCB;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_CAM_ON:  cam_en <= cam_en | mask;
            OP_CAM_OFF: cam_en <= cam_en & ~mask;
            OP_FRAME_DIV: begin
              if (mask[0]) frame_div0 <= arg[3:0];
              if (mask[1]) frame_div1 <= arg[3:0];
            end
            default: ;
          endcase
          resp_code  <= ST_OK;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_SCCB: begin
          if (seq_done) begin
            resp_code  <= ST_OK;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (seq_timeout) begin
            resp_code  <= ST_SCCB_TMO;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            word_cnt   <= 2'd0;
            oversize   <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_cmd_ctrl.sv
// Directed bench for udp_cmd_ctrl: packet-level model with response queue,
// per-cycle comparison of control outputs and literal spot checks.
module tb_udp_cmd_ctrl;

  localparam logic [31:0] MAGIC = 32'h4F56_3536;
  localparam int          T     = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_en = 1'b0;
  logic [31:0] rec_data = 32'd0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = 16'd0;
  logic [1:0]  cam_en;
  logic [3:0]  frame_div0, frame_div1;
  logic        sccb_req, sccb_cam;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_data;
  logic        sccb_ack = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [7:0]  resp_code;
  logic [15:0] resp_seq;
  logic [15:0] drop_cnt;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  udp_cmd_ctrl #(.CMD_MAGIC(MAGIC), .SCCB_TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst), .rec_en(rec_en), .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
    .cam_en(cam_en), .frame_div0(frame_div0), .frame_div1(frame_div1),
    .sccb_req(sccb_req), .sccb_cam(sccb_cam), .sccb_addr(sccb_addr),
    .sccb_data(sccb_data), .sccb_ack(sccb_ack), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_code(resp_code), .resp_seq(resp_seq),
    .drop_cnt(drop_cnt), .fsm_state(fsm_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: {resp cycle[65:34], code[33:26], seq[25:10], cam[9:8], div0[7:4], div1[3:0]}
  logic [1:0]  m_cam = 2'd0;
  logic [3:0]  m_div0 = 4'd0, m_div1 = 4'd0;
  logic [15:0] m_drop = 16'd0;
  int          outstanding = 0;
  logic [65:0] exp_q[$];
  logic [7:0]  last_code = 8'd0;
  logic [15:0] last_seq = 16'd0;

  function automatic logic [65:0] mk(input int c, input logic [7:0] code, input logic [15:0] seq,
                                     input logic [1:0] cam, input logic [3:0] d0, input logic [3:0] d1);
    logic [31:0] c32;
    c32 = c;
    return {c32, code, seq, cam, d0, d1};
  endfunction

  function automatic logic [7:0] model_code(input logic [31:0] w0, input logic [31:0] w1,
                                            input int nwords, input logic [15:0] bytes);
    if (bytes != 16'd12 || nwords != 3) return 8'h01;
    if (w0 != MAGIC) return 8'h02;
    if (w1[31:24] < 8'd1 || w1[31:24] > 8'd4) return 8'h03;
    if (w1[23:16] == 8'd0 || w1[23:16] > 8'd3) return 8'h04;
    return 8'h00;
  endfunction

  // Compare process
  logic        prev_valid = 1'b0;
  logic [7:0]  e_code = 8'd0;
  logic [15:0] e_seq = 16'd0;
  always @(negedge clk) begin
    logic [65:0] e;
    if (resp_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        e_code = e[33:26];
        e_seq  = e[25:10];
        check("resp_cycle", cyc, e[65:34]);
        m_cam  = e[9:8];
        m_div0 = e[7:4];
        m_div1 = e[3:0];
      end
    end
    if (resp_valid) begin
      check("resp_code", resp_code, e_code);
      check("resp_seq", resp_seq, e_seq);
    end
    if (resp_valid && resp_ready) begin
      outstanding = 0;
      last_code = resp_code;
      last_seq  = resp_seq;
    end
    prev_valid = resp_valid;
    check("cam_en", cam_en, m_cam);
    check("frame_div0", frame_div0, m_div0);
    check("frame_div1", frame_div1, m_div1);
    check("drop_cnt", drop_cnt, m_drop);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input int nwords, input logic [15:0] bytes, output int d);
    logic [31:0] w [4];
    logic        acc;
    logic [7:0]  code;
    logic [1:0]  msk, nc;
    logic [3:0]  n0, n1;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w2;
    for (int i = 0; i < nwords; i++) begin
      tick();
      rec_en = 1'b1;
      rec_data = w[i];
      if (i == nwords - 1) begin
        rec_pkt_done = 1'b1;
        rec_byte_num = bytes;
      end
    end
    d = cyc;
    acc = (outstanding == 0);
    tick();
    rec_en = 1'b0; rec_pkt_done = 1'b0; rec_data = 32'd0; rec_byte_num = 16'd0;
    if (!acc) begin
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end else begin
      outstanding = 1;
      code = model_code(w0, w1, nwords, bytes);
      msk = w1[17:16];
      nc = m_cam; n0 = m_div0; n1 = m_div1;
      if (code == 8'h00) begin
        case (w1[31:24])
          8'h01: nc = nc | msk;
          8'h02: nc = nc & ~msk;
          8'h03: begin
            if (msk[0]) n0 = w2[3:0];
            if (msk[1]) n1 = w2[3:0];
          end
          default: ;
        endcase
      end
      if (!(code == 8'h00 && w1[31:24] == 8'h04))
        exp_q.push_back(mk(d + ((code == 8'h00) ? 3 : 2), code, w1[15:0], nc, n0, n1));
    end
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (outstanding != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, outstanding, 0);
  endtask

  // Waits for a request, checks its timing/fields, acks it after 10 cycles.
  task automatic sccb_step(input int start, input logic cam, input logic [15:0] a,
                           input logic [7:0] dt, input logic last, input logic [15:0] seq,
                           output int k);
    int n = 0;
    @(negedge clk);
    while (!sccb_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sccb_req_seen", sccb_req, 1);
    check("sccb_req_cycle", cyc, start);
    check("sccb_cam", sccb_cam, cam);
    check("sccb_addr", sccb_addr, a);
    check("sccb_data", sccb_data, dt);
    repeat (10) tick();
    check("sccb_req_held", sccb_req, 1);
    sccb_ack = 1'b1;
    k = cyc;
    if (last) exp_q.push_back(mk(k + 1, 8'h00, seq, m_cam, m_div0, m_div1));
    tick();
    sccb_ack = 1'b0;
    @(negedge clk);
    check("sccb_req_low_after_ack", sccb_req, 0);
  endtask

  initial begin
    int d, k, n;
    repeat (3) tick();
    check("rst_cam_en", cam_en, 0);
    check("rst_div0", frame_div0, 0);
    check("rst_div1", frame_div1, 0);
    check("rst_sccb_req", sccb_req, 0);
    check("rst_sccb_cam", sccb_cam, 0);
    check("rst_sccb_addr", sccb_addr, 0);
    check("rst_sccb_data", sccb_data, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_code", resp_code, 0);
    check("rst_resp_seq", resp_seq, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    tick();

    // Stream enable / disable / frame decimation
    send_pkt(MAGIC, 32'h0103_0007, 32'h0, 3, 16'd12, d);
    wait_done("wait_enable", 20);
    check("lit_enable_code", last_code, 8'h00);
    check("lit_enable_seq", last_seq, 16'h0007);
    check("lit_enable_cam", cam_en, 2'b11);
    send_pkt(MAGIC, 32'h0201_0008, 32'h0, 3, 16'd12, d);
    wait_done("wait_disable", 20);
    check("lit_disable_cam", cam_en, 2'b10);
    check("lit_disable_seq", last_seq, 16'h0008);
    send_pkt(MAGIC, 32'h0302_0009, 32'h5, 3, 16'd12, d);
    wait_done("wait_div", 20);
    check("lit_div1", frame_div1, 4'd5);
    check("lit_div0", frame_div0, 4'd0);

    // SCCB write to both cameras
    send_pkt(MAGIC, 32'h0403_000A, 32'h3008_0082, 3, 16'd12, d);
    sccb_step(d + 2, 1'b0, 16'h3008, 8'h82, 1'b0, 16'h000A, k);
    sccb_step(k + 2, 1'b1, 16'h3008, 8'h82, 1'b1, 16'h000A, k);
    wait_done("wait_sccb", 20);
    check("lit_sccb_code", last_code, 8'h00);
    check("lit_sccb_seq", last_seq, 16'h000A);

    // Rejections
    send_pkt(MAGIC, 32'h0101_0010, 32'h0, 4, 16'd16, d);
    wait_done("wait_len", 20);
    check("lit_len_code", last_code, 8'h01);
    send_pkt(32'h1234_5678, 32'h0101_0011, 32'h0, 3, 16'd12, d);
    wait_done("wait_magic", 20);
    check("lit_magic_code", last_code, 8'h02);
    send_pkt(MAGIC, 32'h0701_0012, 32'h0, 3, 16'd12, d);
    wait_done("wait_op", 20);
    check("lit_op_code", last_code, 8'h03);
    send_pkt(MAGIC, 32'h0104_0013, 32'h0, 3, 16'd12, d);
    wait_done("wait_mask", 20);
    check("lit_mask_code", last_code, 8'h04);
    check("lit_mask_seq", last_seq, 16'h0013);

    // SCCB timeout
    send_pkt(MAGIC, 32'h0401_0014, 32'h1234_0056, 3, 16'd12, d);
    exp_q.push_back(mk(d + 2 + T, 8'h05, 16'h0014, m_cam, m_div0, m_div1));
    n = 0;
    @(negedge clk);
    while (!sccb_req && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (sccb_req && n < T + 5) begin n++; @(negedge clk); end
    check("tmo_req_cycles", n, T);
    check("tmo_req_low", sccb_req, 0);
    wait_done("wait_tmo", 20);
    check("lit_tmo_code", last_code, 8'h05);

    // Reset while an SCCB request is pending
    send_pkt(MAGIC, 32'h0402_0015, 32'h3100_0011, 3, 16'd12, d);
    n = 0;
    @(negedge clk);
    while (!sccb_req && n < 20) begin @(negedge clk); n++; end
    check("rstmid_req_seen", sccb_req, 1);
    tick();
    rst = 1'b1;
    m_cam = 2'd0; m_div0 = 4'd0; m_div1 = 4'd0; m_drop = 16'd0;
    exp_q.delete();
    outstanding = 0;
    @(negedge clk);
    check("rstmid_sccb_req", sccb_req, 0);
    check("rstmid_sccb_addr", sccb_addr, 0);
    check("rstmid_resp_valid", resp_valid, 0);
    check("rstmid_resp_seq", resp_seq, 0);
    check("rstmid_state", fsm_state, 0);
    tick();
    rst = 1'b0;
    send_pkt(MAGIC, 32'h0101_0020, 32'h0, 3, 16'd12, d);
    wait_done("wait_after_rst", 20);
    check("lit_after_rst_cam", cam_en, 2'b01);
    check("lit_after_rst_seq", last_seq, 16'h0020);

    // Drops while the response is held
    resp_ready = 1'b0;
    send_pkt(MAGIC, 32'h0101_0030, 32'h0, 3, 16'd12, d);
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check("drop_resp_seen", resp_valid, 1);
    send_pkt(MAGIC, 32'h0102_0031, 32'h0, 3, 16'd12, d);
    @(negedge clk);
    check("lit_drop_one", drop_cnt, 16'd1);
    check("lit_drop_seq_kept", resp_seq, 16'h0030);
    tick();
    rec_pkt_done = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (i == 65535) rec_pkt_done = 1'b0;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    @(negedge clk);
    check("lit_drop_sat", drop_cnt, 16'hFFFF);
    tick();
    resp_ready = 1'b1;
    wait_done("wait_drop_resp", 20);
    check("lit_drop_resp_seq", last_seq, 16'h0030);
    repeat (8) tick();
    check("no_extra_resp", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
